paddle_driver: RTL

- Producer side of the puck engine's paddle/tick interface. Generates the slow cursor tick pair (clk_cursor, prev_clk_cursor) and drives both paddle positions (ball1_x/y, ball2_x/y) from two players' debounced direction buttons.
- Consumes collide1/collide2 from the puck engine: on a goal it returns both paddles home and holds them for a freeze period.
- Sits between the button inputs and the puck engine; its position outputs also feed the VGA renderer.

---
 rtl/paddle_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/paddle_driver.sv
// Paddle driver: cursor tick generator, debounced button inputs and paddle
// position registers with goal-triggered return-home and freeze.
module paddle_driver #(
  parameter int TICK_DIV     = 500000,
  parameter int STEP         = 4,
  parameter int DB_TICKS     = 2,
  parameter int FREEZE_TICKS = 60,
  parameter int X_LOWER      = 234,
  parameter int X_MID        = 464,
  parameter int X_UPPER      = 694,
  parameter int Y_LOWER      = 111,
  parameter int Y_UPPER      = 431,
  parameter int P1_HOME_X    = 300,
  parameter int P2_HOME_X    = 628
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] btn1,
  input  logic [3:0] btn2,
  input  logic       collide1,
  input  logic       collide2,
  output logic       clk_cursor,
  output logic       prev_clk_cursor,
  output logic [9:0] ball1_x,
  output logic [9:0] ball1_y,
  output logic [9:0] ball2_x,
  output logic [9:0] ball2_y
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int FRZ_W = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);
  localparam logic [FRZ_W-1:0] FRZ_LOAD = FRZ_W'(FREEZE_TICKS);
  localparam logic [2:0] DB      = 3'(DB_TICKS);
  localparam logic [9:0] HOME_Y  = 10'((Y_LOWER + Y_UPPER) / 2);
  localparam logic [9:0] P1_X    = 10'(P1_HOME_X);
  localparam logic [9:0] P2_X    = 10'(P2_HOME_X);
  localparam logic [9:0] X1_LO   = 10'(X_LOWER);
  localparam logic [9:0] X1_HI   = 10'(X_MID - 1);
  localparam logic [9:0] X2_LO   = 10'(X_MID);
  localparam logic [9:0] X2_HI   = 10'(X_UPPER);
  localparam logic [9:0] Y_LO    = 10'(Y_LOWER);
  localparam logic [9:0] Y_HI    = 10'(Y_UPPER);

  // Sums are formed one bit wider so neither direction can wrap past a bound.
  function automatic logic [9:0] step_inc(input logic [9:0] pos, input logic [9:0] hi);
    logic [10:0] sum;
    sum = {1'b0, pos} + 11'(STEP);
    return (sum > {1'b0, hi}) ? hi : sum[9:0];
  endfunction

  function automatic logic [9:0] step_dec(input logic [9:0] pos, input logic [9:0] lo);
    return ({1'b0, pos} < ({1'b0, lo} + 11'(STEP))) ? lo : (pos - 10'(STEP));
  endfunction

  function automatic logic [9:0] move_axis(input logic [9:0] pos, input logic inc,
                                           input logic dec, input logic [9:0] lo,
                                           input logic [9:0] hi);
    if (inc && !dec) return step_inc(pos, hi);
    if (dec && !inc) return step_dec(pos, lo);
    return pos;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_cursor_q, clk_cursor_d;
  logic             prev_clk_cursor_q, prev_clk_cursor_d;
  logic [7:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [7:0][2:0]  db_q, db_d, db_upd;
  logic [7:0]       act;
  logic [FRZ_W-1:0] frz_q, frz_d;
  logic [9:0]       b1x_q, b1x_d, b1y_q, b1y_d, b2x_q, b2x_d, b2y_q, b2y_d;
  logic             tick;

  assign tick = clk_cursor_q & ~prev_clk_cursor_q;

  always_comb begin
    cnt_d             = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    clk_cursor_d      = (cnt_q < CNT_HALF);
    prev_clk_cursor_d = clk_cursor_q;
    sync1_d           = {btn2, btn1};
    sync2_d           = sync1_q;
    db_upd            = '0;
    act               = '0;
    for (int i = 0; i < 8; i++) begin
      db_upd[i] = sync2_q[i] ? ((db_q[i] >= DB) ? DB : db_q[i] + 3'd1) : 3'd0;
      act[i]    = (db_upd[i] == DB);
    end
    db_d  = db_q;
    frz_d = frz_q;
    b1x_d = b1x_q;
    b1y_d = b1y_q;
    b2x_d = b2x_q;
    b2y_d = b2y_q;
    if (tick) begin
      db_d = db_upd;
      if (collide1 || collide2) begin
        frz_d = FRZ_LOAD;
        b1x_d = P1_X;
        b1y_d = HOME_Y;
        b2x_d = P2_X;
        b2y_d = HOME_Y;
      end else if (frz_q != '0) begin
        frz_d = frz_q - FRZ_W'(1);
      end else begin
        // Button bits per player: 3=up, 2=down, 1=left, 0=right; up lowers y.
        b1x_d = move_axis(b1x_q, act[0], act[1], X1_LO, X1_HI);
        b1y_d = move_axis(b1y_q, act[2], act[3], Y_LO, Y_HI);
        b2x_d = move_axis(b2x_q, act[4], act[5], X2_LO, X2_HI);
        b2y_d = move_axis(b2y_q, act[6], act[7], Y_LO, Y_HI);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q             <= '0;
      clk_cursor_q      <= 1'b0;
      prev_clk_cursor_q <= 1'b0;
      sync1_q           <= '0;
      sync2_q           <= '0;
      db_q              <= '0;
      frz_q             <= '0;
      b1x_q             <= P1_X;
      b1y_q             <= HOME_Y;
      b2x_q             <= P2_X;
      b2y_q             <= HOME_Y;
    end else begin
      cnt_q             <= cnt_d;
      clk_cursor_q      <= clk_cursor_d;
      prev_clk_cursor_q <= prev_clk_cursor_d;
      sync1_q           <= sync1_d;
      sync2_q           <= sync2_d;
      db_q              <= db_d;
      frz_q             <= frz_d;
      b1x_q             <= b1x_d;
      b1y_q             <= b1y_d;
      b2x_q             <= b2x_d;
      b2y_q             <= b2y_d;
    end
  end

  assign clk_cursor      = clk_cursor_q;
  assign prev_clk_cursor = prev_clk_cursor_q;
  assign ball1_x         = b1x_q;
  assign ball1_y         = b1y_q;
  assign ball2_x         = b2x_q;
  assign ball2_y         = b2y_q;
endmodule
